// File: rtl/fifo32_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo32_uart_tx
//
// Drain-side consumer for the 32-bit entropy FIFO. Whenever the block is
// enabled and the FIFO is not empty it pops one word. It then sends that word
// on the UART pin as four 8N1 frames: most-significant byte first, each byte
// LSB first. The FIFO uses a registered read, so the popped word is captured
// one cycle after the pop strobe (the LATCH state).
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2), e.g. 868 for 100 MHz/115200
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   enable        allows a new word fetch; only looked at in IDLE
//   fifo_empty    FIFO empty flag; only looked at in IDLE
//   fifo_rd_en    FIFO pop strobe, one cycle per word
//   fifo_rd_data  FIFO read data, valid the cycle after fifo_rd_en
//   tx            UART serial line, idles high
//   busy          high from FETCH through the last stop bit of a word
//   words_sent    count of fully transmitted words, wraps at 16 bits
// -----------------------------------------------------------------------------
module fifo32_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_rd_data,
    output logic        tx,
    output logic        busy,
    output logic [15:0] words_sent
);

    // The baud counter runs 0..CLKS_PER_BIT-1, so $clog2 bits are enough.
    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [31:0]      word;
    logic [1:0]       byte_idx;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] baud_cnt;

    logic             baud_done;
    logic [2:0]       next_bit_idx;

    // The last cycle of the current bit period.
    assign baud_done    = (baud_cnt == BAUD_LAST);
    assign next_bit_idx = bit_idx + 3'd1;

    // Main transmitter state machine. All outputs are registers and are
    // updated on the same edge as the state, so tx always shows the level
    // that belongs to the state being entered. The bit that goes on the line
    // is word[{byte_idx, bit_idx}]. byte_idx counts down from 3, which sends
    // the most-significant byte first. bit_idx counts up, which sends each
    // byte LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            words_sent <= 16'd0;
            word       <= 32'd0;
            byte_idx   <= 2'd0;
            bit_idx    <= 3'd0;
            baud_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx         <= 1'b1;
                    busy       <= 1'b0;
                    fifo_rd_en <= 1'b0;
                    if (enable && !fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end

                // The pop strobe was raised on entry, so it is high for
                // exactly this one cycle.
                FETCH: begin
                    fifo_rd_en <= 1'b0;
                    state      <= LATCH;
                end

                // The FIFO read data is valid now, one cycle after the pop.
                // Capture it and start the first frame at once.
                LATCH: begin
                    word     <= fifo_rd_data;
                    byte_idx <= 2'd3;
                    bit_idx  <= 3'd0;
                    baud_cnt <= '0;
                    tx       <= 1'b0;
                    state    <= START;
                end

                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        tx       <= word[{byte_idx, 3'd0}];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= next_bit_idx;
                            tx      <= word[{byte_idx, next_bit_idx}];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                // Bytes of one word are sent back to back with no idle time.
                // The word is counted only after its last stop bit.
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (byte_idx != 2'd0) begin
                            byte_idx <= byte_idx - 2'd1;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            words_sent <= words_sent + 16'd1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    tx         <= 1'b1;
                    busy       <= 1'b0;
                    fifo_rd_en <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Checks for simulation only: the pop strobe is a single-cycle pulse,
    // and the line is high and not busy whenever the machine is idle.
    assert property (@(posedge clk) disable iff (rst) fifo_rd_en |=> !fifo_rd_en);
    assert property (@(posedge clk) disable iff (rst) (state == IDLE) |-> (tx && !busy));

endmodule

// File: tb/tb_fifo32_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo32_uart_tx
//
// Directed bench for fifo32_uart_tx with CLKS_PER_BIT = 4.
// - A small FIFO model has a registered read.
// - A UART receiver decodes tx and records each frame's first start cycle.
// - Words, byte order, gaps and counters are checked against constants
//   worked out by hand.
// -----------------------------------------------------------------------------
module tb_fifo32_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        tx;
    logic        busy;
    logic [15:0] words_sent;

    int checks = 0;
    int errors = 0;

    fifo32_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .tx           (tx),
        .busy         (busy),
        .words_sent   (words_sent)
    );

    always #5 clk = ~clk;

    // Cycle counter, used to time-stamp the start bits.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model. The stimulus pushes words and this process pops them.
    // Read data appears on the edge after the pop strobe is sampled.
    logic [31:0] fifo_mem [0:7];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_count = 0;
    int underflow_count = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            pop_count <= pop_count + 1;
            if (wr_ptr == rd_ptr) begin
                underflow_count <= underflow_count + 1;
            end else begin
                fifo_rd_data <= fifo_mem[rd_ptr % 8];
                rd_ptr       <= rd_ptr + 1;
            end
        end
    end

    // UART receiver. It samples on negedges.
    // - The first low sample is start-bit cycle 0.
    // - Bit i is sampled at cycle 4*(i+1)+2.
    // - The stop bit is sampled at cycle 38.
    logic [7:0] rx_bytes [$];
    int         rx_start [$];
    int         frame_err = 0;
    logic [7:0] mon_byte;
    int         mon_start;

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                mon_start = cyc;
                repeat (2) @(negedge clk);
                if (tx !== 1'b0) frame_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_byte[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) frame_err++;
                rx_bytes.push_back(mon_byte);
                rx_start.push_back(mon_start);
                @(negedge clk);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Push one word into the FIFO model; called away from the clock edge.
    task automatic applyStimulus(input logic [31:0] w);
        fifo_mem[wr_ptr % 8] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // Wait, with a cycle limit, until words_sent reaches target. Then let the
    // receiver finish the frame.
    task automatic waitWords(input logic [15:0] target, input int budget);
        int n;
        n = 0;
        while (words_sent !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_words_sent", 32'(words_sent), 32'(target));
        repeat (4) @(negedge clk);
    endtask

    function automatic int getStart(input int idx);
        if (idx < rx_start.size()) return rx_start[idx];
        return -100000;
    endfunction

    // Compare four received bytes (from index base) with the word, MSB first.
    task automatic checkWord(input int base, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp_b;
            exp_b = w[31 - 8 * k -: 8];
            if (rx_bytes.size() > base + k)
                checkOutput("rx_byte", 32'(rx_bytes[base + k]), 32'(exp_b));
            else
                checkOutput("rx_byte_count", 32'(rx_bytes.size()), 32'(base + k + 1));
        end
    endtask

    // Start bits within a word are 40 cycles apart (10 bits of 4 cycles).
    // Between words there are 3 more idle-high cycles: IDLE, FETCH, LATCH.
    task automatic checkGaps(input int base, input int nbytes);
        for (int i = 1; i < nbytes; i++) begin
            int expd;
            expd = ((i % 4) == 0) ? 43 : 40;
            checkOutput("start_gap", 32'(getStart(base + i) - getStart(base + i - 1)), 32'(expd));
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rx_base;
        int pop0;
        int fe0;
        int rd_hits;
        int tx_low_hits;
        int busy_hits;

        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("reset_words_sent", 32'(words_sent), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("idle_no_pop", 32'(pop_count), 32'd0);

        $display("[TB] single word 0xA5C30F81");
        rx_base = rx_bytes.size();
        fe0     = frame_err;
        applyStimulus(32'hA5C30F81);
        enable = 1'b1;
        waitWords(16'd1, 400);
        checkOutput("single_pops", 32'(pop_count), 32'd1);
        checkWord(rx_base, 32'hA5C30F81);
        checkOutput("single_first_byte", 32'(rx_bytes.size() > rx_base ? rx_bytes[rx_base] : 8'h00), 32'h0000_00A5);
        checkOutput("single_span", 32'(getStart(rx_base + 3) + 40 - getStart(rx_base)), 32'd160);
        checkGaps(rx_base, 4);
        checkOutput("single_frame_err", 32'(frame_err - fe0), 32'd0);
        checkOutput("single_busy_done", 32'(busy), 32'd0);

        $display("[TB] back-to-back, four words");
        enable = 1'b0;
        @(negedge clk);
        rx_base = rx_bytes.size();
        fe0     = frame_err;
        pop0    = pop_count;
        applyStimulus(32'h01234567);
        applyStimulus(32'h89ABCDEF);
        applyStimulus(32'hDEADBEEF);
        applyStimulus(32'h0055AAFF);
        enable = 1'b1;
        waitWords(16'd5, 1000);
        checkOutput("b2b_pops", 32'(pop_count - pop0), 32'd4);
        checkWord(rx_base,      32'h01234567);
        checkWord(rx_base + 4,  32'h89ABCDEF);
        checkWord(rx_base + 8,  32'hDEADBEEF);
        checkWord(rx_base + 12, 32'h0055AAFF);
        checkGaps(rx_base, 16);
        checkOutput("b2b_fifo_empty", 32'(fifo_empty), 32'd1);
        checkOutput("b2b_underflow", 32'(underflow_count), 32'd0);
        checkOutput("b2b_frame_err", 32'(frame_err - fe0), 32'd0);

        $display("[TB] enable gating");
        enable = 1'b0;
        @(negedge clk);
        rx_base = rx_bytes.size();
        fe0     = frame_err;
        pop0    = pop_count;
        applyStimulus(32'h3C3C5A5A);
        applyStimulus(32'hF00F1234);
        enable = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("gate_busy_mid_word", 32'(busy), 32'd1);
        enable = 1'b0;
        waitWords(16'd6, 300);
        repeat (100) @(negedge clk);
        checkOutput("gate_pops_held", 32'(pop_count - pop0), 32'd1);
        checkOutput("gate_busy_idle", 32'(busy), 32'd0);
        checkOutput("gate_tx_idle", 32'(tx), 32'd1);
        checkOutput("gate_fifo_not_empty", 32'(fifo_empty), 32'd0);
        enable = 1'b1;
        waitWords(16'd7, 300);
        checkOutput("gate_pops_after", 32'(pop_count - pop0), 32'd2);
        checkWord(rx_base,     32'h3C3C5A5A);
        checkWord(rx_base + 4, 32'hF00F1234);
        checkOutput("gate_frame_err", 32'(frame_err - fe0), 32'd0);

        $display("[TB] empty FIFO with enable high");
        pop0        = pop_count;
        rd_hits     = 0;
        tx_low_hits = 0;
        busy_hits   = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0) rd_hits++;
            if (tx !== 1'b1) tx_low_hits++;
            if (busy !== 1'b0) busy_hits++;
        end
        checkOutput("empty_rd_en", 32'(rd_hits), 32'd0);
        checkOutput("empty_tx_low", 32'(tx_low_hits), 32'd0);
        checkOutput("empty_busy", 32'(busy_hits), 32'd0);
        checkOutput("empty_pops", 32'(pop_count - pop0), 32'd0);

        $display("[TB] async reset in the middle of DATA");
        pop0 = pop_count;
        applyStimulus(32'h12345678);
        repeat (20) @(negedge clk);
        checkOutput("rst_pre_busy", 32'(busy), 32'd1);
        checkOutput("rst_pre_words_sent", 32'(words_sent), 32'd7);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_tx", 32'(tx), 32'd1);
        checkOutput("rst_async_busy", 32'(busy), 32'd0);
        checkOutput("rst_async_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("rst_async_words_sent", 32'(words_sent), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("rst_after_busy", 32'(busy), 32'd0);
        checkOutput("rst_after_tx", 32'(tx), 32'd1);
        checkOutput("rst_after_pops", 32'(pop_count - pop0), 32'd1);
        checkOutput("rst_after_words_sent", 32'(words_sent), 32'd0);

        $display("[TB] words_sent wrap");
        force dut.words_sent = 16'hFFFF;
        @(negedge clk);
        release dut.words_sent;
        @(negedge clk);
        checkOutput("wrap_preload", 32'(words_sent), 32'h0000_FFFF);
        rx_base = rx_bytes.size();
        fe0     = frame_err;
        applyStimulus(32'h5AA5C33C);
        waitWords(16'h0000, 400);
        checkWord(rx_base, 32'h5AA5C33C);
        checkOutput("wrap_frame_err", 32'(frame_err - fe0), 32'd0);
        checkOutput("wrap_underflow", 32'(underflow_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo32_uart_tx.md
Name: fifo32_uart_tx

Overview:
Drain-side consumer for the 32-bit entropy FIFO. It pops one 32-bit word whenever the FIFO is non-empty and the block is enabled. It then serializes the word as four UART 8N1 frames on a single tx pin: most-significant byte first, each byte LSB first. It sits between the TRNG output FIFO and the board UART pin and handles the FIFO's registered read (rd_data valid the cycle after rd_en).

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2; bit counter width is $clog2(CLKS_PER_BIT).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  when high, block may start fetching a new word; sampled only in IDLE.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  FIFO pop strobe; high for exactly one cycle per word.
fifo_rd_data  input  32  FIFO registered read data; valid the cycle after fifo_rd_en.
tx  output  1  UART serial line; idles high.
busy  output  1  high from FETCH through the end of the last stop bit of the word.
words_sent  output  16  count of fully transmitted words; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (async, any state): state=IDLE, tx=1, fifo_rd_en=0, busy=0, words_sent=0, shift word, byte index and bit/baud counters cleared. A word already popped but not fully sent is discarded.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, FETCH, LATCH, START, DATA, STOP.
- IDLE: tx=1, busy=0. If enable=1 and fifo_empty=0 at a clock edge -> FETCH.
- FETCH: exactly 1 cycle; fifo_rd_en=1, busy=1 -> LATCH.
- LATCH: exactly 1 cycle; fifo_rd_en=0. At the end edge, capture fifo_rd_data into the word register, set byte index=3 -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA with bit index 0.
- DATA: tx = word[8*byte_idx + bit_idx] for CLKS_PER_BIT cycles per bit, bits 0..7 (LSB first). After bit 7 -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - byte_idx>0: decrement byte_idx -> START (no idle gap between bytes).
  - byte_idx==0: words_sent+1 -> IDLE.
- Frame timing: one byte = 10*CLKS_PER_BIT cycles; one word = 40*CLKS_PER_BIT cycles after LATCH.
- Back-to-back words: minimum gap between the last stop bit of one word and the next start bit is 3 cycles (IDLE, FETCH, LATCH) with tx=1.
- enable deassertion mid-word: the current word always completes; the block then stays in IDLE until enable=1.
- fifo_empty is ignored outside IDLE. fifo_rd_en is never asserted while fifo_empty=1 was sampled in IDLE, so no underflow pop occurs.
- Exactly one pop per transmitted word; no speculative or double reads.
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary; no fractional baud correction.
- enable and fifo_empty are synchronous to clk; no synchronizers are required.

Test Plan:
- Reset values: assert rst mid-DATA with CLKS_PER_BIT=4 -> tx=1, busy=0, fifo_rd_en=0, words_sent=0 immediately (same cycle, async); after release, stays idle while fifo_empty=1.
- Single word: CLKS_PER_BIT=4, FIFO holds 0xA5C30F81, enable=1 -> one fifo_rd_en pulse; tx decodes bytes 0xA5, 0xC3, 0x0F, 0x81 in order (first byte bits 1,0,1,0,0,1,0,1). Stop bit is high each byte; total 160 cycles from first start bit to end of last stop; words_sent=1.
- Back-to-back: FIFO holds 4 words (full, DEPTH=4) -> 4 pops, 4×4 bytes in FIFO order; exactly 3 idle-high cycles between words; fifo_empty=1 at end; words_sent=4; no fifo_rd_en while empty.
- Enable gating: deassert enable during byte 2 of word 1 with 2 words queued -> word 1 completes; no second fifo_rd_en until enable=1; then word 2 transmits correctly.
- Empty FIFO: enable=1, fifo_empty=1 for 1000 cycles -> fifo_rd_en never asserted; tx constant 1; busy=0.
- Counter wrap: preload 0xFFFF sent words (or force the counter) and send one word -> words_sent=0x0000.
